// File: rtl/axi_matrix_accel.sv
// Matrix-multiply accelerator: C = A x B on 32-bit integers.
// AXI-Lite register file for control, AXI-Stream slaves for A/B, master for C.
module axi_matrix_accel #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MAX_DIM = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_axi_awvalid,
  output logic              s_axi_awready,
  input  logic [ADDR_W-1:0] s_axi_awaddr,
  input  logic              s_axi_wvalid,
  output logic              s_axi_wready,
  input  logic [DATA_W-1:0] s_axi_wdata,
  output logic              s_axi_bvalid,
  input  logic              s_axi_bready,
  output logic [1:0]        s_axi_bresp,
  input  logic              s_axi_arvalid,
  output logic              s_axi_arready,
  input  logic [ADDR_W-1:0] s_axi_araddr,
  output logic              s_axi_rvalid,
  input  logic              s_axi_rready,
  output logic [DATA_W-1:0] s_axi_rdata,
  output logic [1:0]        s_axi_rresp,
  input  logic              s_axis_a_tvalid,
  output logic              s_axis_a_tready,
  input  logic [DATA_W-1:0] s_axis_a_tdata,
  input  logic              s_axis_a_tlast,
  input  logic              s_axis_b_tvalid,
  output logic              s_axis_b_tready,
  input  logic [DATA_W-1:0] s_axis_b_tdata,
  input  logic              s_axis_b_tlast,
  output logic              m_axis_c_tvalid,
  input  logic              m_axis_c_tready,
  output logic [DATA_W-1:0] m_axis_c_tdata,
  output logic              m_axis_c_tlast,
  output logic              done
);
  localparam int DIM_W = $clog2(MAX_DIM + 1);
  localparam int IDX_W = $clog2(MAX_DIM * MAX_DIM);
  localparam int CNT_W = IDX_W + 1;
  localparam int DEPTH = MAX_DIM * MAX_DIM;

  localparam logic [ADDR_W-1:0] ADDR_START = ADDR_W'(32'h00);
  localparam logic [ADDR_W-1:0] ADDR_DONE  = ADDR_W'(32'h04);
  localparam logic [ADDR_W-1:0] ADDR_CFG_M = ADDR_W'(32'h08);
  localparam logic [ADDR_W-1:0] ADDR_CFG_K = ADDR_W'(32'h0C);
  localparam logic [ADDR_W-1:0] ADDR_CFG_N = ADDR_W'(32'h10);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_COMPUTE = 3'd2,
    ST_OUTPUT  = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

  // A zero dimension still runs a 1-wide product; oversize dimensions saturate.
  function automatic logic [DIM_W-1:0] clamp_dim(input logic [DATA_W-1:0] v);
    if (v == '0) clamp_dim = DIM_W'(1);
    else if (v > DATA_W'(MAX_DIM)) clamp_dim = DIM_W'(MAX_DIM);
    else clamp_dim = v[DIM_W-1:0];
  endfunction

  function automatic logic [CNT_W-1:0] dim_prod(input logic [DIM_W-1:0] x, input logic [DIM_W-1:0] y);
    dim_prod = CNT_W'(x) * CNT_W'(y);
  endfunction

  state_t            state_q, state_d;
  logic [DATA_W-1:0] cfg_m_q, cfg_m_d, cfg_k_q, cfg_k_d, cfg_n_q, cfg_n_d;
  logic [DIM_W-1:0]  dim_m_q, dim_m_d, dim_k_q, dim_k_d, dim_n_q, dim_n_d;
  logic [DIM_W-1:0]  ci_q, ci_d, cj_q, cj_d, ck_q, ck_d;
  logic [CNT_W-1:0]  a_cnt_q, a_cnt_d, b_cnt_q, b_cnt_d, out_cnt_q, out_cnt_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic [DATA_W-1:0] a_mem_q [DEPTH];
  logic [DATA_W-1:0] a_mem_d [DEPTH];
  logic [DATA_W-1:0] b_mem_q [DEPTH];
  logic [DATA_W-1:0] b_mem_d [DEPTH];
  logic [DATA_W-1:0] c_mem_q [DEPTH];
  logic [DATA_W-1:0] c_mem_d [DEPTH];
  logic              done_q, done_d, awready_q, awready_d, bvalid_q, bvalid_d;
  logic              arready_q, arready_d, rvalid_q, rvalid_d;
  logic [1:0]        bresp_q, bresp_d, rresp_q, rresp_d;
  logic [DATA_W-1:0] rdata_q, rdata_d, c_tdata_q, c_tdata_d;
  logic              a_tready_q, a_tready_d, b_tready_q, b_tready_d;
  logic              c_tvalid_q, c_tvalid_d, c_tlast_q, c_tlast_d;

  logic              wr_hs_s, rd_hs_s, start_s, stop_s;
  logic [CNT_W-1:0]  a_idx_s, b_idx_s, c_idx_s;
  logic [DATA_W-1:0] mac_s;
  logic              unused_s;

  assign wr_hs_s = awready_q && s_axi_awvalid && s_axi_wvalid;
  assign rd_hs_s = arready_q && s_axi_arvalid;
  assign start_s = wr_hs_s && (s_axi_awaddr == ADDR_START) && s_axi_wdata[0]
                   && ((state_q == ST_IDLE) || (state_q == ST_DONE));
  assign stop_s  = wr_hs_s && (s_axi_awaddr == ADDR_START) && !s_axi_wdata[0]
                   && (state_q == ST_DONE);

  // Row-major addressing: A[i][k] at i*K+k, B[k][j] at k*N+j, C[i][j] at i*N+j.
  assign a_idx_s = CNT_W'(ci_q) * CNT_W'(dim_k_q) + CNT_W'(ck_q);
  assign b_idx_s = CNT_W'(ck_q) * CNT_W'(dim_n_q) + CNT_W'(cj_q);
  assign c_idx_s = CNT_W'(ci_q) * CNT_W'(dim_n_q) + CNT_W'(cj_q);
  assign mac_s   = ((ck_q == '0) ? '0 : acc_q)
                   + a_mem_q[a_idx_s[IDX_W-1:0]] * b_mem_q[b_idx_s[IDX_W-1:0]];
  assign unused_s = s_axis_a_tlast ^ s_axis_b_tlast;

  assign s_axi_awready   = awready_q;
  assign s_axi_wready    = awready_q;
  assign s_axi_bvalid    = bvalid_q;
  assign s_axi_bresp     = bresp_q;
  assign s_axi_arready   = arready_q;
  assign s_axi_rvalid    = rvalid_q;
  assign s_axi_rdata     = rdata_q;
  assign s_axi_rresp     = rresp_q;
  assign s_axis_a_tready = a_tready_q;
  assign s_axis_b_tready = b_tready_q;
  assign m_axis_c_tvalid = c_tvalid_q;
  assign m_axis_c_tdata  = c_tdata_q;
  assign m_axis_c_tlast  = c_tlast_q;
  assign done            = done_q;

  // Next-state for the register file, both AXI-Lite channels, the FSM and stream outputs.
  always_comb begin
    state_d = state_q;
    cfg_m_d = cfg_m_q;  cfg_k_d = cfg_k_q;  cfg_n_d = cfg_n_q;
    dim_m_d = dim_m_q;  dim_k_d = dim_k_q;  dim_n_d = dim_n_q;
    ci_d = ci_q;  cj_d = cj_q;  ck_d = ck_q;  acc_d = acc_q;
    a_cnt_d = a_cnt_q;  b_cnt_d = b_cnt_q;  out_cnt_d = out_cnt_q;
    a_mem_d = a_mem_q;  b_mem_d = b_mem_q;  c_mem_d = c_mem_q;
    done_d = done_q;
    bresp_d = bresp_q;  rresp_d = rresp_q;  rdata_d = rdata_q;
    awready_d = s_axi_awvalid && s_axi_wvalid && !bvalid_q && !awready_q;
    arready_d = s_axi_arvalid && !rvalid_q && !arready_q;
    bvalid_d  = (bvalid_q && s_axi_bready) ? 1'b0 : bvalid_q;
    rvalid_d  = (rvalid_q && s_axi_rready) ? 1'b0 : rvalid_q;

    if (wr_hs_s) begin
      bvalid_d = 1'b1;
      bresp_d  = RESP_OKAY;
      case (s_axi_awaddr)
        ADDR_START, ADDR_DONE: ;
        ADDR_CFG_M: cfg_m_d = s_axi_wdata;
        ADDR_CFG_K: cfg_k_d = s_axi_wdata;
        ADDR_CFG_N: cfg_n_d = s_axi_wdata;
        default:    bresp_d = RESP_SLVERR;
      endcase
    end else begin
      bresp_d = bresp_q;
    end

    if (rd_hs_s) begin
      rvalid_d = 1'b1;
      rresp_d  = RESP_OKAY;
      case (s_axi_araddr)
        ADDR_START: rdata_d = '0;
        ADDR_DONE:  rdata_d = {{(DATA_W-1){1'b0}}, done_q};
        ADDR_CFG_M: rdata_d = cfg_m_q;
        ADDR_CFG_K: rdata_d = cfg_k_q;
        ADDR_CFG_N: rdata_d = cfg_n_q;
        default: begin
          rdata_d = '0;
          rresp_d = RESP_SLVERR;
        end
      endcase
    end else begin
      rresp_d = rresp_q;
    end

    if (start_s) begin
      dim_m_d = clamp_dim(cfg_m_q);
      dim_k_d = clamp_dim(cfg_k_q);
      dim_n_d = clamp_dim(cfg_n_q);
      a_cnt_d = '0;
      b_cnt_d = '0;
      done_d  = 1'b0;
      state_d = ST_LOAD;
    end else if (stop_s) begin
      done_d  = 1'b0;
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_LOAD: begin
          if (s_axis_a_tvalid && a_tready_q) begin
            a_mem_d[a_cnt_q[IDX_W-1:0]] = s_axis_a_tdata;
            a_cnt_d = a_cnt_q + CNT_W'(1);
          end else begin
            a_cnt_d = a_cnt_q;
          end
          if (s_axis_b_tvalid && b_tready_q) begin
            b_mem_d[b_cnt_q[IDX_W-1:0]] = s_axis_b_tdata;
            b_cnt_d = b_cnt_q + CNT_W'(1);
          end else begin
            b_cnt_d = b_cnt_q;
          end
          if ((a_cnt_q == dim_prod(dim_m_q, dim_k_q)) && (b_cnt_q == dim_prod(dim_k_q, dim_n_q))) begin
            ci_d = '0;  cj_d = '0;  ck_d = '0;
            state_d = ST_COMPUTE;
          end else begin
            state_d = ST_LOAD;
          end
        end
        ST_COMPUTE: begin
          if (ck_q == dim_k_q - DIM_W'(1)) begin
            c_mem_d[c_idx_s[IDX_W-1:0]] = mac_s;
            ck_d = '0;
            if (cj_q == dim_n_q - DIM_W'(1)) begin
              cj_d = '0;
              if (ci_q == dim_m_q - DIM_W'(1)) begin
                out_cnt_d = '0;
                state_d   = ST_OUTPUT;
              end else begin
                ci_d = ci_q + DIM_W'(1);
              end
            end else begin
              cj_d = cj_q + DIM_W'(1);
            end
          end else begin
            acc_d = mac_s;
            ck_d  = ck_q + DIM_W'(1);
          end
        end
        ST_OUTPUT: begin
          if (c_tvalid_q && m_axis_c_tready) begin
            if (out_cnt_q == dim_prod(dim_m_q, dim_n_q) - CNT_W'(1)) begin
              done_d  = 1'b1;
              state_d = ST_DONE;
            end else begin
              out_cnt_d = out_cnt_q + CNT_W'(1);
            end
          end else begin
            out_cnt_d = out_cnt_q;
          end
        end
        ST_IDLE, ST_DONE: ;
        default: state_d = ST_IDLE;
      endcase
    end

    // Stream outputs are registered from next state, so they line up with the state they belong to.
    a_tready_d = (state_d == ST_LOAD) && (a_cnt_d < dim_prod(dim_m_d, dim_k_d));
    b_tready_d = (state_d == ST_LOAD) && (b_cnt_d < dim_prod(dim_k_d, dim_n_d));
    c_tvalid_d = (state_d == ST_OUTPUT);
    c_tdata_d  = (state_d == ST_OUTPUT) ? c_mem_d[out_cnt_d[IDX_W-1:0]] : '0;
    c_tlast_d  = (state_d == ST_OUTPUT) && (out_cnt_d == dim_prod(dim_m_d, dim_n_d) - CNT_W'(1));
  end

  // State register bank with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cfg_m_q <= DATA_W'(2);  cfg_k_q <= DATA_W'(2);  cfg_n_q <= DATA_W'(2);
      dim_m_q <= DIM_W'(1);   dim_k_q <= DIM_W'(1);   dim_n_q <= DIM_W'(1);
      ci_q <= '0;  cj_q <= '0;  ck_q <= '0;  acc_q <= '0;
      a_cnt_q <= '0;  b_cnt_q <= '0;  out_cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        a_mem_q[i] <= '0;
        b_mem_q[i] <= '0;
        c_mem_q[i] <= '0;
      end
      done_q <= 1'b0;  awready_q <= 1'b0;  bvalid_q <= 1'b0;  bresp_q <= 2'b00;
      arready_q <= 1'b0;  rvalid_q <= 1'b0;  rdata_q <= '0;  rresp_q <= 2'b00;
      a_tready_q <= 1'b0;  b_tready_q <= 1'b0;
      c_tvalid_q <= 1'b0;  c_tdata_q <= '0;  c_tlast_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cfg_m_q <= cfg_m_d;  cfg_k_q <= cfg_k_d;  cfg_n_q <= cfg_n_d;
      dim_m_q <= dim_m_d;  dim_k_q <= dim_k_d;  dim_n_q <= dim_n_d;
      ci_q <= ci_d;  cj_q <= cj_d;  ck_q <= ck_d;  acc_q <= acc_d;
      a_cnt_q <= a_cnt_d;  b_cnt_q <= b_cnt_d;  out_cnt_q <= out_cnt_d;
      a_mem_q <= a_mem_d;  b_mem_q <= b_mem_d;  c_mem_q <= c_mem_d;
      done_q <= done_d;  awready_q <= awready_d;  bvalid_q <= bvalid_d;  bresp_q <= bresp_d;
      arready_q <= arready_d;  rvalid_q <= rvalid_d;  rdata_q <= rdata_d;  rresp_q <= rresp_d;
      a_tready_q <= a_tready_d;  b_tready_q <= b_tready_d;
      c_tvalid_q <= c_tvalid_d;  c_tdata_q <= c_tdata_d;  c_tlast_q <= c_tlast_d;
    end
  end
endmodule

// File: tb/tb_axi_matrix_accel.sv
// Self-checking bench for axi_matrix_accel: AXI-Lite master, stream sources/sink,
// and a plain-arithmetic matrix-product reference.
module tb_axi_matrix_accel;
  logic        clk = 1'b0;
  logic        rst;
  logic        s_axi_awvalid, s_axi_awready, s_axi_wvalid, s_axi_wready;
  logic [31:0] s_axi_awaddr, s_axi_wdata, s_axi_araddr, s_axi_rdata;
  logic        s_axi_bvalid, s_axi_bready, s_axi_arvalid, s_axi_arready;
  logic        s_axi_rvalid, s_axi_rready;
  logic [1:0]  s_axi_bresp, s_axi_rresp;
  logic        s_axis_a_tvalid, s_axis_a_tready, s_axis_a_tlast;
  logic        s_axis_b_tvalid, s_axis_b_tready, s_axis_b_tlast;
  logic [31:0] s_axis_a_tdata, s_axis_b_tdata, m_axis_c_tdata;
  logic        m_axis_c_tvalid, m_axis_c_tready, m_axis_c_tlast, done;

  axi_matrix_accel #(.ADDR_W(32), .DATA_W(32), .MAX_DIM(4)) dut (
    .clk(clk), .rst(rst),
    .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready), .s_axi_awaddr(s_axi_awaddr),
    .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready), .s_axi_wdata(s_axi_wdata),
    .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready), .s_axi_bresp(s_axi_bresp),
    .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready), .s_axi_araddr(s_axi_araddr),
    .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready), .s_axi_rdata(s_axi_rdata),
    .s_axi_rresp(s_axi_rresp),
    .s_axis_a_tvalid(s_axis_a_tvalid), .s_axis_a_tready(s_axis_a_tready),
    .s_axis_a_tdata(s_axis_a_tdata), .s_axis_a_tlast(s_axis_a_tlast),
    .s_axis_b_tvalid(s_axis_b_tvalid), .s_axis_b_tready(s_axis_b_tready),
    .s_axis_b_tdata(s_axis_b_tdata), .s_axis_b_tlast(s_axis_b_tlast),
    .m_axis_c_tvalid(m_axis_c_tvalid), .m_axis_c_tready(m_axis_c_tready),
    .m_axis_c_tdata(m_axis_c_tdata), .m_axis_c_tlast(m_axis_c_tlast),
    .done(done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;
  logic [31:0] a_v [16];
  logic [31:0] b_v [16];
  logic [31:0] c_exp [16];
  logic [31:0] got [16];
  int em, ek, en;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int eff(input logic [31:0] v);
    if (v == 32'd0) return 1;
    else if (v > 32'd4) return 4;
    else return int'(v);
  endfunction

  task automatic axi_write(input logic [31:0] addr, input logic [31:0] data, output logic [1:0] resp);
    int n;
    s_axi_awaddr = addr;  s_axi_wdata = data;
    s_axi_awvalid = 1'b1;  s_axi_wvalid = 1'b1;
    n = 0;
    while (!s_axi_awready && n < 50) begin tick(); n++; end
    if (n >= 50) begin
      check("aw_timeout", 32'd0, 32'd1);
      s_axi_awvalid = 1'b0;  s_axi_wvalid = 1'b0;  resp = 2'b11;
      return;
    end
    check("wready_with_awready", {31'd0, s_axi_wready}, 32'd1);
    tick();
    s_axi_awvalid = 1'b0;  s_axi_wvalid = 1'b0;  s_axi_bready = 1'b1;
    n = 0;
    while (!s_axi_bvalid && n < 50) begin tick(); n++; end
    if (n >= 50) check("b_timeout", 32'd0, 32'd1);
    resp = s_axi_bresp;
    tick();
    s_axi_bready = 1'b0;
  endtask

  task automatic axi_read(input logic [31:0] addr, output logic [31:0] data, output logic [1:0] resp);
    int n;
    s_axi_araddr = addr;  s_axi_arvalid = 1'b1;
    n = 0;
    while (!s_axi_arready && n < 50) begin tick(); n++; end
    if (n >= 50) begin
      check("ar_timeout", 32'd0, 32'd1);
      s_axi_arvalid = 1'b0;  data = 32'hx;  resp = 2'b11;
      return;
    end
    tick();
    s_axi_arvalid = 1'b0;  s_axi_rready = 1'b1;
    n = 0;
    while (!s_axi_rvalid && n < 50) begin tick(); n++; end
    if (n >= 50) check("r_timeout", 32'd0, 32'd1);
    data = s_axi_rdata;  resp = s_axi_rresp;
    tick();
    s_axi_rready = 1'b0;
  endtask

  task automatic wr_ok(input string tag, input logic [31:0] addr, input logic [31:0] data);
    logic [1:0] r;
    axi_write(addr, data, r);
    check(tag, {30'd0, r}, 32'd0);
  endtask

  // Reference: effective dimensions after clamping, fresh operands, C by triple loop.
  task automatic set_model(input logic [31:0] cm, input logic [31:0] ck, input logic [31:0] cn, input bit rnd);
    logic [31:0] acc;
    em = eff(cm);  ek = eff(ck);  en = eff(cn);
    for (int i = 0; i < 16; i++) begin
      a_v[i] = rnd ? $urandom : 32'(i);
      b_v[i] = rnd ? $urandom : 32'(i);
    end
    for (int i = 0; i < em; i++)
      for (int j = 0; j < en; j++) begin
        acc = 32'd0;
        for (int k = 0; k < ek; k++) acc = acc + a_v[i*ek+k] * b_v[k*en+j];
        c_exp[i*en+j] = acc;
      end
  endtask

  task automatic send_a(input int cnt, input int gap);
    int n;
    for (int i = 0; i < cnt; i++) begin
      s_axis_a_tvalid = 1'b0;
      repeat ($urandom_range(0, gap)) tick();
      s_axis_a_tdata = a_v[i];  s_axis_a_tlast = (i == cnt - 1);  s_axis_a_tvalid = 1'b1;
      n = 0;
      while (!s_axis_a_tready && n < 300) begin tick(); n++; end
      if (n >= 300) begin check("a_timeout", 32'd0, 32'd1); break; end
      tick();
    end
    s_axis_a_tvalid = 1'b0;  s_axis_a_tlast = 1'b0;
  endtask

  task automatic send_b(input int cnt, input int gap);
    int n;
    for (int i = 0; i < cnt; i++) begin
      s_axis_b_tvalid = 1'b0;
      repeat ($urandom_range(0, gap)) tick();
      s_axis_b_tdata = b_v[i];  s_axis_b_tlast = (i == cnt - 1);  s_axis_b_tvalid = 1'b1;
      n = 0;
      while (!s_axis_b_tready && n < 300) begin tick(); n++; end
      if (n >= 300) begin check("b_timeout", 32'd0, 32'd1); break; end
      tick();
    end
    s_axis_b_tvalid = 1'b0;  s_axis_b_tlast = 1'b0;
  endtask

  task automatic recv_c(input int pct, input int stall_at);
    int n, changed, words;
    logic [31:0] sd;
    logic sl;
    words = em * en;
    for (int w = 0; w < words; w++) begin
      if (w == stall_at) begin
        m_axis_c_tready = 1'b0;
        n = 0;
        while (!m_axis_c_tvalid && n < 500) begin tick(); n++; end
        sd = m_axis_c_tdata;  sl = m_axis_c_tlast;  changed = 0;
        repeat (50) begin
          tick();
          if (m_axis_c_tdata !== sd || m_axis_c_tlast !== sl || m_axis_c_tvalid !== 1'b1) changed++;
        end
        check("c_stall_stable", 32'(changed), 32'd0);
      end
      n = 0;
      while (n < 500) begin
        m_axis_c_tready = ($urandom_range(0, 99) < pct);
        if (m_axis_c_tvalid && m_axis_c_tready) break;
        tick();
        n++;
      end
      if (n >= 500) begin
        check("c_timeout", 32'd0, 32'd1);
        m_axis_c_tready = 1'b0;
        return;
      end
      got[w] = m_axis_c_tdata;
      check("c_tdata", m_axis_c_tdata, c_exp[w]);
      check("c_tlast", {31'd0, m_axis_c_tlast}, {31'd0, w == words - 1});
      tick();
    end
    m_axis_c_tready = 1'b0;
    check("done_after_c", {31'd0, done}, 32'd1);
    check("c_tvalid_after_frame", {31'd0, m_axis_c_tvalid}, 32'd0);
  endtask

  task automatic start_run(input string tag);
    wr_ok(tag, 32'h00, 32'd1);
    check("done_cleared_by_start", {31'd0, done}, 32'd0);
  endtask

  task automatic full_run(input logic [31:0] cm, input logic [31:0] ck, input logic [31:0] cn,
                          input bit rnd, input int gap, input int pct, input int stall_at);
    wr_ok("cfg_m_wr", 32'h08, cm);
    wr_ok("cfg_k_wr", 32'h0C, ck);
    wr_ok("cfg_n_wr", 32'h10, cn);
    set_model(cm, ck, cn, rnd);
    start_run("start_wr");
    fork
      send_a(em * ek, gap);
      send_b(ek * en, gap);
    join
    recv_c(pct, stall_at);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached before the summary");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    logic [1:0] rr;
    logic [31:0] pick;
    rst = 1'b1;
    s_axi_awvalid = 1'b0;  s_axi_wvalid = 1'b0;  s_axi_bready = 1'b0;
    s_axi_arvalid = 1'b0;  s_axi_rready = 1'b0;
    s_axi_awaddr = 32'd0;  s_axi_wdata = 32'd0;  s_axi_araddr = 32'd0;
    s_axis_a_tvalid = 1'b0;  s_axis_a_tdata = 32'd0;  s_axis_a_tlast = 1'b0;
    s_axis_b_tvalid = 1'b0;  s_axis_b_tdata = 32'd0;  s_axis_b_tlast = 1'b0;
    m_axis_c_tready = 1'b0;
    repeat (3) tick();

    check("rst_lite_outs", {26'd0, s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_arready,
                            s_axi_rvalid, done}, 32'd0);
    check("rst_resp", {28'd0, s_axi_bresp, s_axi_rresp}, 32'd0);
    check("rst_rdata", s_axi_rdata, 32'd0);
    check("rst_stream_outs", {28'd0, s_axis_a_tready, s_axis_b_tready, m_axis_c_tvalid,
                              m_axis_c_tlast}, 32'd0);
    check("rst_c_tdata", m_axis_c_tdata, 32'd0);
    rst = 1'b0;
    tick();
    axi_read(32'h08, rd, rr);  check("rst_cfg_m", rd, 32'd2);
    axi_read(32'h10, rd, rr);  check("rst_cfg_n", rd, 32'd2);

    // Basic 2x2 product with gappy sources.
    full_run(32'd2, 32'd2, 32'd2, 1'b0, 3, 100, -1);
    check("basic_c0", got[0], 32'd2);
    check("basic_c1", got[1], 32'd3);
    check("basic_c2", got[2], 32'd6);
    check("basic_c3", got[3], 32'd11);

    axi_read(32'h04, rd, rr);
    check("done_reg", rd, 32'd1);
    check("done_reg_rresp", {30'd0, rr}, 32'd0);
    axi_read(32'h0C, rd, rr);  check("cfg_k_rd", rd, 32'd2);
    axi_read(32'h00, rd, rr);  check("start_reads_zero", rd, 32'd0);
    wr_ok("done_wr_ignored_resp", 32'h04, 32'd0);
    check("done_wr_ignored", {31'd0, done}, 32'd1);
    axi_write(32'h14, 32'd5, rr);  check("unmapped_bresp", {30'd0, rr}, 32'd2);
    axi_read(32'h14, rd, rr);
    check("unmapped_rresp", {30'd0, rr}, 32'd2);
    check("unmapped_rdata", rd, 32'd0);

    // Reset while computing a 4x4x4 product, then the basic run again.
    wr_ok("cfg_m_wr", 32'h08, 32'd4);
    wr_ok("cfg_k_wr", 32'h0C, 32'd4);
    wr_ok("cfg_n_wr", 32'h10, 32'd4);
    set_model(32'd4, 32'd4, 32'd4, 1'b1);
    start_run("start_wr");
    fork
      send_a(16, 0);
      send_b(16, 0);
    join
    repeat (5) tick();
    check("mid_compute_no_tvalid", {31'd0, m_axis_c_tvalid}, 32'd0);
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    check("done_after_rst", {31'd0, done}, 32'd0);
    check("readies_after_rst", {30'd0, s_axis_a_tready, s_axis_b_tready}, 32'd0);
    tick();
    axi_read(32'h08, rd, rr);  check("cfg_m_after_rst", rd, 32'd2);
    full_run(32'd2, 32'd2, 32'd2, 1'b0, 2, 100, -1);
    check("rerun_c3", got[3], 32'd11);

    // Three back-to-back runs, each closed with START=0.
    for (int r = 0; r < 3; r++) begin
      full_run(32'd2, 32'd2, 32'd2, 1'b0, 2, 80, -1);
      check("b2b_c0", got[0], 32'd2);
      check("b2b_c3", got[3], 32'd11);
      wr_ok("stop_wr", 32'h00, 32'd0);
      check("done_cleared_by_stop", {31'd0, done}, 32'd0);
      axi_read(32'h04, rd, rr);  check("done_reg_after_stop", rd, 32'd0);
      check("idle_no_ready", {30'd0, s_axis_a_tready, s_axis_b_tready}, 32'd0);
    end

    // Random sink backpressure with a long stall in the middle of the frame.
    full_run(32'd3, 32'd2, 32'd4, 1'b1, 1, 40, 5);

    // Restart straight from DONE.
    wr_ok("cfg_m_wr", 32'h08, 32'd2);
    wr_ok("cfg_k_wr", 32'h0C, 32'd3);
    wr_ok("cfg_n_wr", 32'h10, 32'd1);
    set_model(32'd2, 32'd3, 32'd1, 1'b1);
    start_run("restart_wr");
    fork
      send_a(em * ek, 2);
      send_b(ek * en, 2);
    join
    recv_c(70, -1);

    // START and a CFG write during LOAD must not disturb the run in progress.
    wr_ok("cfg_n_wr", 32'h10, 32'd2);
    set_model(32'd2, 32'd3, 32'd2, 1'b1);
    start_run("start_wr");
    send_a(em * ek, 1);
    tick();
    check("a_ready_low_when_full", {31'd0, s_axis_a_tready}, 32'd0);
    wr_ok("start_in_load_resp", 32'h00, 32'd1);
    wr_ok("cfg_in_load_resp", 32'h10, 32'd1);
    send_b(ek * en, 1);
    recv_c(100, -1);

    // Randomised dimensions, including zero and oversize values.
    for (int r = 0; r < 4; r++) begin
      logic [31:0] dv [3];
      for (int d = 0; d < 3; d++) begin
        pick = 32'($urandom_range(0, 6));
        dv[d] = (pick == 32'd6) ? 32'h8000_0000 : pick;
      end
      full_run(dv[0], dv[1], dv[2], 1'b1, 2, 60, -1);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/axi_matrix_accel.md
Name: axi_matrix_accel

Overview:
- Matrix-multiply accelerator computing C = A × B on 32-bit integers.
- Dimensions and start/done are controlled through an AXI-Lite slave register file.
- A and B arrive on AXI-Stream slaves; C leaves on an AXI-Stream master.
- Sits behind the system AXI-Lite interconnect, with DMA-style stream sources and sink.

Parameters:
- ADDR_W, 32, AXI-Lite address width.
- DATA_W, 32, AXI-Lite data width and stream element width.
- MAX_DIM, 4, maximum M, K, N; sizes each of the A/B/C buffers at MAX_DIM*MAX_DIM words.

Ports:
- clk in 1: single clock.
- rst in 1: synchronous, active-high reset.
- s_axi_awvalid in 1 / s_axi_awready out 1 / s_axi_awaddr in ADDR_W: write address channel.
- s_axi_wvalid in 1 / s_axi_wready out 1 / s_axi_wdata in DATA_W: write data channel.
- s_axi_bvalid out 1 / s_axi_bready in 1 / s_axi_bresp out 2: write response.
- s_axi_arvalid in 1 / s_axi_arready out 1 / s_axi_araddr in ADDR_W: read address channel.
- s_axi_rvalid out 1 / s_axi_rready in 1 / s_axi_rdata out DATA_W / s_axi_rresp out 2: read data channel.
- s_axis_a_tvalid in 1 / s_axis_a_tready out 1 / s_axis_a_tdata in DATA_W / s_axis_a_tlast in 1: matrix A stream.
- s_axis_b_tvalid in 1 / s_axis_b_tready out 1 / s_axis_b_tdata in DATA_W / s_axis_b_tlast in 1: matrix B stream.
- m_axis_c_tvalid out 1 / m_axis_c_tready in 1 / m_axis_c_tdata out DATA_W / m_axis_c_tlast out 1: matrix C stream.
- done out 1: sticky completion flag; same value as DONE register bit0.

Behaviour:
- Register map:
  - 0x00 START: write-only action; reads return 0.
  - 0x04 DONE: bit0 = done, other bits 0; read-only, writes ignored.
  - 0x08 CFG_M, 0x0C CFG_K, 0x10 CFG_N: R/W, full 32 bits stored.
- Reset state: CFG_M, CFG_K, CFG_N = 2. FSM to IDLE, all counters and buffers' valid state cleared, done=0.
- Reset values of outputs: all ready/valid outputs 0, bresp/rresp 0, rdata 0, m_axis_c_tdata 0, m_axis_c_tlast 0.
- AXI-Lite write:
  - When awvalid && wvalid && !bvalid: pulse awready and wready together for 1 cycle and perform the write.
  - bvalid asserts the next cycle and holds until bready is sampled high.
  - bresp: 00 for a mapped address, 10 (SLVERR) for unmapped; no state change on SLVERR.
- AXI-Lite read:
  - When arvalid && !rvalid: pulse arready for 1 cycle.
  - rvalid and rdata are driven the next cycle; rdata is held stable until rready is sampled high.
  - rresp: 00 for a mapped address, 10 for unmapped (rdata 0).
- START write with wdata[0]=1:
  - In IDLE or DONE: latch the CFG values, clear done, enter LOAD the next cycle.
  - In LOAD, COMPUTE or OUTPUT: ignored; bresp is still 00.
- START write with wdata[0]=0: in DONE, clear done and return to IDLE; otherwise no effect.
- Dimension latching: each latched dimension of 0 becomes 1; a value above MAX_DIM becomes MAX_DIM. CFG writes while busy affect only the next run.
- FSM IDLE → LOAD → COMPUTE → OUTPUT → DONE.
  - LOAD:
    - s_axis_a_tready=1 while a_cnt < M*K; s_axis_b_tready=1 while b_cnt < K*N.
    - Each handshake stores the beat row-major and increments its counter; A and B are accepted independently and concurrently.
    - tlast inputs are ignored; beat counts define frame length.
    - Move to COMPUTE the cycle after both counts complete.
  - COMPUTE:
    - One multiply-accumulate per cycle, M*N*K cycles total.
    - C[i][j] = sum over k of A[i][k]*B[k][j], truncated to the low 32 bits (wrap, no saturation).
  - OUTPUT:
    - Stream M*N words row-major.
    - tvalid stays high with data stable until the handshake.
    - tlast=1 only on the final word.
    - Backpressure of any length is tolerated with no data loss.
  - DONE: entered the cycle after the final C handshake; done=1, held until START or reset.
- Stream readies are 0 outside LOAD; m_axis_c_tvalid is 0 outside OUTPUT.
- Reset mid-operation (any state): immediate return to reset state.
  - Partially loaded data is discarded.
  - The next run requires a fresh START and full A/B frames.

Test Plan:
- Reset, then write CFG_K=2 and START=1; send A=[0,1,2,3] and B=[0,1,2,3] with random tvalid gaps → C stream [2,3,6,11] with tlast on the 4th word; done=1.
- After done, read 0x04 → rdata bit0=1, rresp=00. Read 0x0C → 2. Write/read 0x14 → bresp/rresp=10.
- Assert rst while the FSM is in COMPUTE, then rerun the first scenario → identical C output. done was 0 immediately after reset.
- Three back-to-back runs:
  - Each run: START=1, stream A/B, wait done, then write START=0.
  - Required: done returns to 0 and the FSM is in IDLE after each START=0; all three runs produce [2,3,6,11].
- Random m_axis_c_tready during OUTPUT, then a 50-cycle hard stall → tdata/tlast stable while stalled, no words lost or duplicated.
- START=1 while in DONE (restart) → done clears, a new run completes. START=1 written during LOAD → ignored, the current run is unaffected.
